// File: rtl/gate_bist_pkg.sv
// -----------------------------------------------------------------------------
// gate_bist_pkg
// Shared definitions for the gate BIST controller: the controller state
// encoding and the widths of the settle and round counters.
// No ports (package).
// -----------------------------------------------------------------------------
package gate_bist_pkg;

    localparam int SETTLE_CNT_W = 8;
    localparam int ROUND_CNT_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/gate_bist_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk   - sampling clock
//   rst_n - asynchronous active-low reset, clears both flops to 0
//   d     - asynchronous input
//   q     - synchronized output, two clk cycles of latency
// -----------------------------------------------------------------------------
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gate_bist.sv
// -----------------------------------------------------------------------------
// gate_bist
// Built-in self test for a single gate (inverter/ring or buffer). Each run
// drives the vectors 0 then 1, ROUNDS times over. Every vector gets one DRIVE
// cycle, SETTLE_CYCLES settle cycles and one CHECK cycle in which the
// synchronized response is compared against the expected value.
// Ports:
//   clk            - clock, all state on the rising edge
//   rst_n          - asynchronous active-low reset
//   start          - run request, only looked at in IDLE
//   dut_in         - stimulus to the gate under test
//   dut_out        - response from the gate under test (asynchronous)
//   busy           - high from the first DRIVE through the last CHECK
//   done           - one-cycle pulse at the end of a run
//   pass           - last completed run had no mismatches; held until start
//   err_count      - saturating mismatch count of the current/last run
//   first_fail_vec - stimulus of the first mismatch (valid if err_count != 0)
// -----------------------------------------------------------------------------
module gate_bist
    import gate_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int ROUNDS        = 2,
    parameter int INVERT        = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_vec
);

    localparam logic                    EXP_FLIP    = (INVERT != 0);
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES);
    localparam logic [ROUND_CNT_W-1:0]  LAST_ROUND  = ROUND_CNT_W'(ROUNDS - 1);
    localparam logic [ERR_W-1:0]        ERR_MAX     = '1;

    state_t                  state;
    state_t                  state_next;
    logic [SETTLE_CNT_W-1:0] settle_cnt;
    logic [SETTLE_CNT_W-1:0] settle_next;
    logic [ROUND_CNT_W-1:0]  round_cnt;
    logic [ROUND_CNT_W-1:0]  round_next;
    logic                    vec;
    logic                    vec_next;
    logic                    dut_in_next;
    logic [ERR_W-1:0]        err_next;
    logic                    ffv_next;
    logic                    pass_next;
    logic                    dut_out_sync;
    logic                    mismatch;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dut_out),
        .q     (dut_out_sync)
    );

    // The only place the gate polarity matters.
    assign mismatch = dut_out_sync != (dut_in ^ EXP_FLIP);

    assign busy = (state == DRIVE) || (state == SETTLE) || (state == CHECK);
    assign done = (state == DONE);

    always_comb begin
        state_next  = state;
        settle_next = settle_cnt;
        round_next  = round_cnt;
        vec_next    = vec;
        dut_in_next = dut_in;
        err_next    = err_count;
        ffv_next    = first_fail_vec;
        pass_next   = pass;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next  = DRIVE;
                    round_next  = '0;
                    vec_next    = 1'b0;
                    dut_in_next = 1'b0;
                    err_next    = '0;
                    ffv_next    = 1'b0;
                    pass_next   = 1'b0;
                end
            end

            // dut_in is updated on the edge that enters DRIVE, so the gate
            // already sees the new vector during the DRIVE cycle itself. That
            // lets the two synchronizer stages fill even with SETTLE_CYCLES=1.
            DRIVE: begin
                settle_next = SETTLE_LOAD;
                state_next  = SETTLE;
            end

            SETTLE: begin
                settle_next = settle_cnt - 1'b1;
                if (settle_cnt <= SETTLE_CNT_W'(1)) begin
                    state_next = CHECK;
                end
            end

            CHECK: begin
                if (mismatch) begin
                    if (err_count != ERR_MAX) begin
                        err_next = err_count + 1'b1;
                    end
                    // Count is cleared at start and never wraps, so zero here
                    // means this is the first mismatch of the run.
                    if (err_count == '0) begin
                        ffv_next = dut_in;
                    end
                end

                if (!vec) begin
                    vec_next    = 1'b1;
                    dut_in_next = 1'b1;
                    state_next  = DRIVE;
                end else if (round_cnt == LAST_ROUND) begin
                    // pass is registered on entry to DONE so it is already
                    // valid alongside the done pulse, including this check.
                    state_next = DONE;
                    pass_next  = (err_next == '0);
                end else begin
                    round_next  = round_cnt + 1'b1;
                    vec_next    = 1'b0;
                    dut_in_next = 1'b0;
                    state_next  = DRIVE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            settle_cnt     <= '0;
            round_cnt      <= '0;
            vec            <= 1'b0;
            dut_in         <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= 1'b0;
            pass           <= 1'b0;
        end else begin
            state          <= state_next;
            settle_cnt     <= settle_next;
            round_cnt      <= round_next;
            vec            <= vec_next;
            dut_in         <= dut_in_next;
            err_count      <= err_next;
            first_fail_vec <= ffv_next;
            pass           <= pass_next;
        end
    end

endmodule

// File: tb/tb_gate_bist.sv
// -----------------------------------------------------------------------------
// tb_gate_bist
// Scoreboarded bench for gate_bist. Three instances:
//   u_dut - defaults (INVERT=1, ROUNDS=2, SETTLE_CYCLES=4), gate model selectable
//   u_buf - INVERT=0, ROUNDS=3, dut_out looped back from dut_in (buffer)
//   u_sat - ERR_W=2, ROUNDS=4, INVERT=1, dut_out looped back (always mismatches)
// Expected run results are queued when a run is launched; per-instance
// monitors pop and compare on each done pulse.
// -----------------------------------------------------------------------------
module tb_gate_bist;

    typedef struct {
        int cycles;
        int err;
        bit pass;
        bit ffv;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start0;
    logic       start_b;
    int         mode;

    logic       dut_in0, dut_out0, busy0, done0, pass0, ffv0;
    logic [7:0] err0;
    logic       dut_in1, busy1, done1, pass1, ffv1;
    logic [7:0] err1;
    logic       dut_in2, busy2, done2, pass2, ffv2;
    logic [1:0] err2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int checks   = 0;
    int failures = 0;

    int cnt0 = 0, cnt1 = 0, cnt2 = 0;
    bit bad0 = 0, bad1 = 0, bad2 = 0;

    // Gate model for u_dut: 0 = inverter, 1 = stuck at 1, 2 = buffer.
    assign dut_out0 = (mode == 0) ? ~dut_in0 : (mode == 1) ? 1'b1 : dut_in0;

    gate_bist u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start0),
        .dut_in         (dut_in0),
        .dut_out        (dut_out0),
        .busy           (busy0),
        .done           (done0),
        .pass           (pass0),
        .err_count      (err0),
        .first_fail_vec (ffv0)
    );

    gate_bist #(.SETTLE_CYCLES(4), .ROUNDS(3), .INVERT(0), .ERR_W(8)) u_buf (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start_b),
        .dut_in         (dut_in1),
        .dut_out        (dut_in1),
        .busy           (busy1),
        .done           (done1),
        .pass           (pass1),
        .err_count      (err1),
        .first_fail_vec (ffv1)
    );

    gate_bist #(.SETTLE_CYCLES(4), .ROUNDS(4), .INVERT(1), .ERR_W(2)) u_sat (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start_b),
        .dut_in         (dut_in2),
        .dut_out        (dut_in2),
        .busy           (busy2),
        .done           (done2),
        .pass           (pass2),
        .err_count      (err2),
        .first_fail_vec (ffv2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Vector driven during busy cycle n: 6 cycles per vector (1+4+1).
    function automatic logic exp_vec(input int n);
        return ((n / 6) % 2) != 0;
    endfunction

    task automatic push(input int id, input int cyc, input int err, input bit p, input bit f);
        exp_t e;
        e.cycles = cyc;
        e.err    = err;
        e.pass   = p;
        e.ffv    = f;
        case (id)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic finish_run(input int id, input int cyc, input int err,
                              input bit p, input bit f, input bit bad);
        exp_t e;
        bit   have;
        have = 0;
        case (id)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
        endcase
        if (!have) begin
            checks++;
            failures++;
            $display("FAIL i%0d_unexpected_done actual=done expected=no_done t=%0t", id, $time);
        end else begin
            chk($sformatf("i%0d_run_len", id), cyc, e.cycles);
            chk($sformatf("i%0d_err_count", id), err, e.err);
            chk($sformatf("i%0d_pass", id), int'(p), int'(e.pass));
            if (e.err != 0) chk($sformatf("i%0d_first_fail_vec", id), int'(f), int'(e.ffv));
            chk($sformatf("i%0d_dut_in_seq", id), int'(bad), 0);
        end
    endtask

    // Monitors: count busy cycles, check the vector sequence, score on done.
    always @(negedge clk) begin
        if (!rst_n) begin
            cnt0 = 0; bad0 = 0;
        end else begin
            if (busy0) begin
                if (dut_in0 !== exp_vec(cnt0)) bad0 = 1;
                cnt0++;
            end
            if (done0) begin
                finish_run(0, cnt0, int'(err0), pass0, ffv0, bad0);
                cnt0 = 0; bad0 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt1 = 0; bad1 = 0;
        end else begin
            if (busy1) begin
                if (dut_in1 !== exp_vec(cnt1)) bad1 = 1;
                cnt1++;
            end
            if (done1) begin
                finish_run(1, cnt1, int'(err1), pass1, ffv1, bad1);
                cnt1 = 0; bad1 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt2 = 0; bad2 = 0;
        end else begin
            if (busy2) begin
                if (dut_in2 !== exp_vec(cnt2)) bad2 = 1;
                cnt2++;
            end
            if (done2) begin
                finish_run(2, cnt2, int'(err2), pass2, ffv2, bad2);
                cnt2 = 0; bad2 = 0;
            end
        end
    end

    task automatic pulse_start0();
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_done(input int id, input int budget);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            case (id)
                0: seen = done0;
                1: seen = done1;
                default: seen = done2;
            endcase
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL i%0d_done_timeout actual=no_done expected=done budget=%0d", id, budget);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start0  = 1'b0;
        start_b = 1'b0;
        mode    = 0;

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_pass", int'(pass0), 0);
        chk("rst_err_count", int'(err0), 0);
        chk("rst_dut_in", int'(dut_in0), 0);
        chk("rst_first_fail_vec", int'(ffv0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Inverter, clean run.
        mode = 0;
        push(0, 24, 0, 1'b1, 1'b0);
        pulse_start0();
        wait_done(0, 40);

        // Output stuck at 1: vector 1 fails in both rounds.
        mode = 1;
        push(0, 24, 2, 1'b0, 1'b1);
        pulse_start0();
        wait_done(0, 40);

        // Buffer against INVERT=1: every check fails, first on vector 0.
        mode = 2;
        push(0, 24, 4, 1'b0, 1'b0);
        pulse_start0();
        wait_done(0, 40);

        // start pulses while busy must not restart or extend the run.
        mode = 0;
        push(0, 24, 0, 1'b1, 1'b0);
        pulse_start0();
        repeat (5) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (10) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_done(0, 40);
        repeat (4) @(negedge clk);
        chk("pass_held", int'(pass0), 1);

        // Abort with reset during SETTLE of round 2 (vector 1) after a failure.
        mode = 1;
        pulse_start0();
        repeat (20) @(negedge clk);
        chk("pre_abort_err_count", int'(err0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy0), 0);
        chk("abort_done", int'(done0), 0);
        chk("abort_pass", int'(pass0), 0);
        chk("abort_err_count", int'(err0), 0);
        chk("abort_dut_in", int'(dut_in0), 0);
        chk("abort_first_fail_vec", int'(ffv0), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_abort_pass", int'(pass0), 0);
        chk("post_abort_busy", int'(busy0), 0);
        mode = 0;
        push(0, 24, 0, 1'b1, 1'b0);
        pulse_start0();
        wait_done(0, 40);

        // start held high: back-to-back runs with a single IDLE cycle between.
        push(0, 24, 0, 1'b1, 1'b0);
        push(0, 24, 0, 1'b1, 1'b0);
        @(negedge clk);
        start0 = 1'b1;
        wait_done(0, 40);
        @(negedge clk);
        chk("b2b_idle_busy", int'(busy0), 0);
        @(negedge clk);
        chk("b2b_drive_busy", int'(busy0), 1);
        wait_done(0, 40);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("b2b_stopped_busy", int'(busy0), 0);

        // Buffer with INVERT=0 over 3 rounds, and saturation with ERR_W=2.
        push(1, 36, 0, 1'b1, 1'b0);
        push(2, 48, 3, 1'b0, 1'b0);
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        wait_done(2, 80);
        repeat (5) @(negedge clk);

        chk("pending_i0", q0.size(), 0);
        chk("pending_i1", q1.size(), 0);
        chk("pending_i2", q2.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_bist.md
GATE_BIST -- requirements
Module: gate_bist

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4: clock cycles between driving dut_in and sampling, range 1..255.
REQ-002 SHALL have parameter ROUNDS, default 2: passes over the vector set {0,1}, range 1..255.
REQ-003 SHALL have parameter INVERT, default 1: 1 = expected response is ~stimulus (inverter/ring), 0 = expected equals stimulus (buffer).
REQ-004 SHALL have parameter ERR_W, default 8: width of err_count.
Ports (name, direction, width, meaning):
REQ-005 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have start  input  1  run request, sampled only in IDLE.
REQ-008 SHALL have dut_in  output  1  stimulus to gate under test.
REQ-009 SHALL have dut_out  input  1  response from gate under test, asynchronous to clk.
REQ-010 SHALL have busy  output  1  high from first DRIVE cycle through last CHECK cycle.
REQ-011 SHALL have done  output  1  single-cycle pulse at run end.
REQ-012 SHALL have pass  output  1  high iff last completed run had err_count==0; held until next start.
REQ-013 SHALL have err_count  output  ERR_W  mismatch count of current/last run, saturating.
REQ-014 SHALL have first_fail_vec  output  1  stimulus value of first mismatch of the run; valid when err_count!=0.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-016 IDLE + start=1 SHALL go to DRIVE next cycle, clearing err_count, pass, vector index and round counter.
REQ-017 DRIVE SHALL set dut_in to current vector (first vector 0, then 1) and go to SETTLE for one-cycle load of the settle counter.
REQ-018 SETTLE SHALL hold dut_in stable for exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-019 dut_out SHALL pass through a two-flop synchronizer; CHECK compares the synchronized value against expected (dut_in XOR INVERT).
REQ-020 On mismatch in CHECK, err_count SHALL increment by 1, saturating at 2^ERR_W-1 (no wrap); first mismatch of a run SHALL latch first_fail_vec.
REQ-021 After CHECK, next vector SHALL follow (0->1); after vector 1, round counter increments; after ROUNDS rounds, go to DONE, else to DRIVE.
REQ-022 Total run length SHALL be 2*ROUNDS*(SETTLE_CYCLES+2) cycles from first DRIVE to last CHECK inclusive; DONE lasts one cycle then IDLE.
REQ-023 DONE SHALL pulse done=1 and set pass=(err_count==0) with the final CHECK result included.
REQ-024 start asserted while busy or in DONE SHALL be ignored; no restart, no counter effect.
REQ-025 start held high continuously SHALL cause back-to-back runs, each beginning the cycle after DONE's IDLE.
REQ-026 dut_in SHALL retain its last driven value in IDLE/DONE.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, synchronizer flops=0, all counters=0.
REQ-028 Reset mid-run SHALL abort without done pulse; pass stays 0 after release until a run completes.
REQ-029 Deassertion SHALL be sampled on clk; first start accepted on the cycle after rst_n is seen high.

Structure
REQ-030 Shared package gate_bist_pkg SHALL hold the FSM state enum and the counter-width constants (8-bit settle and round counters).
REQ-031 Synchronizer SHALL be a separate sub-module sync2 (two flops, async active-low reset to 0).
REQ-032 Expected-value computation SHALL be the only use of INVERT; no other parameter-dependent datapath.

Verification
REQ-033 INVERT=1, DUT=inverter, start pulse -> done after 2*2*(4+2)=24 busy cycles, pass=1, err_count=0.
REQ-034 INVERT=0, DUT=buffer, ROUNDS=3 -> pass=1, err_count=0, dut_in sequence 0,1,0,1,0,1.
REQ-035 INVERT=1, dut_out tied 1 -> err_count=2 (vector 1 fails each round, ROUNDS=2), first_fail_vec=1, pass=0.
REQ-036 ERR_W=2, ROUNDS=4, dut_out tied to dut_in with INVERT=1 -> 8 mismatches, err_count saturates at 3, pass=0.
REQ-037 rst_n pulsed low during SETTLE of round 2 -> outputs at reset values immediately, no done pulse; next start runs cleanly to pass=1.
REQ-038 start pulsed during busy -> ignored, run length unchanged at 24 cycles, single done pulse.
